// File: rtl/z80_int_ctrl_if.sv
// Shared CPU IO bus (upper address byte, strobes, data) plus the interrupt request line
// seen by the interrupt controller.
interface z80_int_ctrl_if;
    logic [7:0] Address;
    logic       IORQ;
    logic       RD;
    logic       WR;
    logic       M1;
    logic [7:0] DataIn;
    logic [7:0] DataOut;
    logic       DataOE;
    logic       nINT;

    modport master (
        output Address, IORQ, RD, WR, M1, DataIn,
        input  DataOut, DataOE, nINT
    );

    modport slave (
        input  Address, IORQ, RD, WR, M1, DataIn,
        output DataOut, DataOE, nINT
    );
endinterface

// File: rtl/z80_int_ctrl.sv
// IO-mapped priority interrupt controller for the A-Z80: edge-latched requests, mask, in-service
// nesting and IM2 vectors. Define Z80_INT_CTRL_LEVEL_EN to add the MODE register (level channels).
module z80_int_ctrl #(
    parameter int         NUM_CH   = 4,
    parameter logic [7:0] VEC_BASE = 8'h80,
    parameter logic [7:0] IO_PORT  = 8'h04
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic [NUM_CH-1:0] irq_in,
    z80_int_ctrl_if.slave     bus
);
    localparam logic [7:0] PORT_PEND = IO_PORT;
    localparam logic [7:0] PORT_MASK = IO_PORT + 8'd1;
    localparam logic [7:0] PORT_ISR  = IO_PORT + 8'd2;
    localparam logic [7:0] PORT_MODE = IO_PORT + 8'd3;
    localparam logic [7:0] CH_MASK   = 8'((9'd1 << NUM_CH) - 9'd1);
    localparam logic [7:0] VEC_SPUR  = VEC_BASE + 8'(2 * NUM_CH);

    typedef enum logic [1:0] {
        ACK_IDLE,
        ACK_DRIVE,
        ACK_DRAIN
    } ackState_t;

    function automatic logic [7:0] chanVector(input logic [3:0] ch);
        return VEC_BASE + {3'b000, ch, 1'b0};
    endfunction

    function automatic logic [3:0] lowestSet(input logic [7:0] v);
        logic [3:0] idx;
        idx = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Channel state is held 8 bits wide; bits at or above NUM_CH are forced to zero.
    logic [7:0] irqWide;
    logic [7:0] irqSync_p0, irqSync_p1, irqLast_p2;
    logic [7:0] irqRise;
    logic [7:0] pendReg, maskReg, isrReg;
    logic [7:0] pendNext, maskNext, isrNext;
    logic [7:0] levelCh;
    logic [7:0] eligible, ackHot, isrLowHot;
    logic       blocked;
    logic       ackHit;
    logic [3:0] ackCh;
    logic [7:0] ackVec;
    logic [7:0] vecLatch;
    logic       nIntReg;
    logic       ioCycle, ackQual;
    logic       selPend, selMask, selIsr, selMode, portHit;
    logic       rdQual, wrQual, wrSeen, wrStart;
    logic [7:0] readData;
    ackState_t  ackState, ackNext;
    logic       ackStart, vecDrive;

    assign irqWide = 8'(irq_in);
    assign irqRise = irqSync_p1 & ~irqLast_p2;

    assign ioCycle = bus.IORQ & ~bus.M1;
    assign ackQual = bus.IORQ & bus.M1;
    assign selPend = (bus.Address == PORT_PEND);
    assign selMask = (bus.Address == PORT_MASK);
    assign selIsr  = (bus.Address == PORT_ISR);
`ifdef Z80_INT_CTRL_LEVEL_EN
    logic [7:0] modeReg;
    assign selMode = (bus.Address == PORT_MODE);
    assign levelCh = modeReg;
`else
    assign selMode = 1'b0;
    assign levelCh = 8'h00;
`endif
    assign portHit = selPend | selMask | selIsr | selMode;
    assign rdQual  = ioCycle & bus.RD & portHit;
    assign wrQual  = ioCycle & bus.WR & portHit;
    assign wrStart = wrQual & ~wrSeen;

    // A channel qualifies only if it outranks every in-service channel, itself included.
    always_comb begin
        blocked  = 1'b0;
        eligible = 8'h00;
        for (int i = 0; i < 8; i++) begin
            blocked     = blocked | isrReg[i];
            eligible[i] = pendReg[i] & maskReg[i] & ~blocked;
        end
    end

    assign ackHit    = |eligible;
    assign ackHot    = eligible & (~eligible + 8'd1);
    assign isrLowHot = isrReg & (~isrReg + 8'd1);
    assign ackCh     = lowestSet(eligible);
    assign ackVec    = ackHit ? chanVector(ackCh) : VEC_SPUR;

    always_comb begin
        ackNext  = ackState;
        ackStart = 1'b0;
        vecDrive = 1'b0;
        case (ackState)
            ACK_IDLE: begin
                if (ackQual) begin
                    ackStart = 1'b1;
                    ackNext  = ACK_DRIVE;
                end
            end
            ACK_DRIVE: begin
                if (ackQual) vecDrive = 1'b1;
                else         ackNext  = ACK_IDLE;
            end
            ACK_DRAIN: begin
                if (!ackQual) ackNext = ACK_IDLE;
            end
            default: ackNext = ACK_IDLE;
        endcase
    end

    // Fresh edges are ORed in last so they survive a same-cycle W1C or acknowledge.
    always_comb begin
        pendNext = pendReg;
        maskNext = maskReg;
        isrNext  = isrReg;
        if (wrStart && selPend) pendNext = pendNext & ~(bus.DataIn & ~levelCh);
        if (wrStart && selMask) maskNext = bus.DataIn;
        if (wrStart && selIsr)  isrNext  = isrNext & ~isrLowHot;
        if (ackStart) begin
            isrNext  = isrNext | ackHot;
            pendNext = pendNext & ~(ackHot & ~levelCh);
        end
        pendNext = pendNext | irqRise;
        pendNext = ((pendNext & ~levelCh) | (irqSync_p1 & levelCh)) & CH_MASK;
        maskNext = maskNext & CH_MASK;
        isrNext  = isrNext & CH_MASK;
    end

    // Stage boundary: synchroniser, edge history and all architectural registers.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            irqSync_p0 <= 8'h00;
            irqSync_p1 <= 8'h00;
            irqLast_p2 <= 8'h00;
            pendReg    <= 8'h00;
            maskReg    <= 8'h00;
            isrReg     <= 8'h00;
            nIntReg    <= 1'b1;
            // Treat a write strobe already present at reset as seen, so it is not acted on.
            wrSeen     <= 1'b1;
        end else begin
            irqSync_p0 <= irqWide & CH_MASK;
            irqSync_p1 <= irqSync_p0;
            irqLast_p2 <= irqSync_p1;
            pendReg    <= pendNext;
            maskReg    <= maskNext;
            isrReg     <= isrNext;
            nIntReg    <= ~ackHit;
            wrSeen     <= wrQual;
        end
    end

    // An acknowledge in flight at reset is drained without driving a vector.
    always_ff @(posedge CLK) begin
        if (!nRESET) ackState <= ACK_DRAIN;
        else         ackState <= ackNext;
    end

    always_ff @(posedge CLK) begin
        if (ackStart) vecLatch <= ackVec;
    end

`ifdef Z80_INT_CTRL_LEVEL_EN
    always_ff @(posedge CLK) begin
        if (!nRESET)                modeReg <= 8'h00;
        else if (wrStart && selMode) modeReg <= bus.DataIn & CH_MASK;
    end
`endif

    always_comb begin
        readData = 8'h00;
        if (selPend) readData = pendReg;
        if (selMask) readData = maskReg;
        if (selIsr)  readData = isrReg;
`ifdef Z80_INT_CTRL_LEVEL_EN
        if (selMode) readData = modeReg;
`endif
        bus.DataOE  = vecDrive | rdQual;
        bus.DataOut = 8'h00;
        if (vecDrive)    bus.DataOut = vecLatch;
        else if (rdQual) bus.DataOut = readData;
    end

    assign bus.nINT = nIntReg;
endmodule

// File: tb/tb_z80_int_ctrl.sv
// Self-checking bench for z80_int_ctrl: vector table, hand-built timing corners and a randomized
// run against a register-level reference model.
`timescale 1ns/1ps
module tb_z80_int_ctrl;
    localparam int         NUM_CH   = 4;
    localparam logic [7:0] VEC_BASE = 8'h80;
    localparam logic [7:0] IO_PORT  = 8'h04;
    localparam logic [7:0] P_PEND   = 8'h04;
    localparam logic [7:0] P_MASK   = 8'h05;
    localparam logic [7:0] P_ISR    = 8'h06;
    localparam logic [7:0] P_MODE   = 8'h07;
    localparam logic [7:0] CHM      = 8'h0F;

    logic              CLK = 1'b0;
    logic              nRESET;
    logic [NUM_CH-1:0] irq_in;
    z80_int_ctrl_if bus();

    z80_int_ctrl #(.NUM_CH(NUM_CH), .VEC_BASE(VEC_BASE), .IO_PORT(IO_PORT)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef enum int {OP_NINT, OP_RD, OP_NORD, OP_WR, OP_PULSE, OP_ACK} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[$];

    logic [7:0] mPend, mMask, mIsr;

    function automatic void addv(input op_e op, input logic [7:0] a, input logic [7:0] d,
                                 input logic [7:0] e);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic busIdle();
        bus.Address = 8'h00; bus.DataIn = 8'h00;
        bus.IORQ = 1'b0; bus.RD = 1'b0; bus.WR = 1'b0; bus.M1 = 1'b0;
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic ioWrite(input logic [7:0] port, input logic [7:0] data);
        bus.Address = port; bus.DataIn = data; bus.IORQ = 1'b1; bus.WR = 1'b1;
        @(negedge CLK);
        bus.IORQ = 1'b0; bus.WR = 1'b0;
        @(negedge CLK);
    endtask

    task automatic ioRead(input logic [7:0] port, output logic [7:0] data, output logic oe);
        bus.Address = port; bus.IORQ = 1'b1; bus.RD = 1'b1;
        #1;
        data = bus.DataOut; oe = bus.DataOE;
        bus.IORQ = 1'b0; bus.RD = 1'b0;
        @(negedge CLK);
    endtask

    task automatic ackCycle(output logic [7:0] v1, output logic oe1, output logic [7:0] v2,
                            output logic oe2, output logic oeAfter);
        bus.M1 = 1'b1; bus.IORQ = 1'b1;
        @(negedge CLK);
        v1 = bus.DataOut; oe1 = bus.DataOE;
        @(negedge CLK);
        v2 = bus.DataOut; oe2 = bus.DataOE;
        bus.M1 = 1'b0; bus.IORQ = 1'b0;
        #1;
        oeAfter = bus.DataOE;
        @(negedge CLK);
    endtask

    task automatic pulse(input int ch);
        irq_in[ch] = 1'b1;
        @(negedge CLK);
        irq_in[ch] = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic doReset();
        nRESET = 1'b0; irq_in = '0; busIdle();
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic readCheck(input string name, input logic [7:0] port, input logic [7:0] exp);
        logic [7:0] d;
        logic oe;
        ioRead(port, d, oe);
        check8({name, " oe"}, 8'(oe), 8'h01);
        check8(name, d, exp);
    endtask

    task automatic ackCheck(input string name, input logic [7:0] exp);
        logic [7:0] v1, v2;
        logic oe1, oe2, oeA;
        ackCycle(v1, oe1, v2, oe2, oeA);
        check8({name, " oe"}, 8'(oe1), 8'h01);
        check8({name, " vec"}, v1, exp);
        check8({name, " vecT3"}, v2, exp);
        check8({name, " oe release"}, 8'(oeA), 8'h00);
    endtask

    // Reference: channel that an acknowledge would pick, or -1 when the ack is spurious.
    function automatic int modelPick();
        int lowIsr;
        lowIsr = NUM_CH;
        for (int i = NUM_CH - 1; i >= 0; i--) if (mIsr[i]) lowIsr = i;
        for (int i = 0; i < lowIsr; i++) if (mPend[i] && mMask[i]) return i;
        return -1;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic oe;
        nRESET = 1'b0; irq_in = '0; busIdle();
        @(negedge CLK);

        addv(OP_NINT, 0, 0, 1);
        addv(OP_RD, P_PEND, 0, 8'h00);
        addv(OP_RD, P_MASK, 0, 8'h00);
        addv(OP_RD, P_ISR, 0, 8'h00);
        addv(OP_WR, P_MASK, 8'hFF, 0);
        addv(OP_RD, P_MASK, 0, 8'h0F);
        addv(OP_PULSE, 2, 0, 0);
        addv(OP_NINT, 0, 0, 0);
        addv(OP_RD, P_PEND, 0, 8'h04);
        addv(OP_ACK, 0, 0, 8'h84);
        addv(OP_RD, P_PEND, 0, 8'h00);
        addv(OP_RD, P_ISR, 0, 8'h04);
        addv(OP_NINT, 0, 0, 1);
        addv(OP_PULSE, 3, 0, 0);
        addv(OP_NINT, 0, 0, 1);
        addv(OP_RD, P_PEND, 0, 8'h08);
        addv(OP_PULSE, 0, 0, 0);
        addv(OP_NINT, 0, 0, 0);
        addv(OP_ACK, 0, 0, 8'h80);
        addv(OP_RD, P_ISR, 0, 8'h05);
        addv(OP_NINT, 0, 0, 1);
        addv(OP_WR, P_ISR, 8'h5A, 0);
        addv(OP_RD, P_ISR, 0, 8'h04);
        addv(OP_NINT, 0, 0, 1);
        addv(OP_WR, P_ISR, 8'h00, 0);
        addv(OP_RD, P_ISR, 0, 8'h00);
        addv(OP_NINT, 0, 0, 0);
        addv(OP_ACK, 0, 0, 8'h86);
        addv(OP_RD, P_ISR, 0, 8'h08);
        addv(OP_WR, P_ISR, 8'h00, 0);
        addv(OP_WR, P_PEND, 8'hFF, 0);
        addv(OP_RD, P_PEND, 0, 8'h00);
        addv(OP_PULSE, 1, 0, 0);
        addv(OP_NINT, 0, 0, 0);
        addv(OP_WR, P_MASK, 8'h00, 0);
        addv(OP_NINT, 0, 0, 1);
        addv(OP_ACK, 0, 0, 8'h88);
        addv(OP_RD, P_PEND, 0, 8'h02);
        addv(OP_RD, P_ISR, 0, 8'h00);
        addv(OP_WR, P_MASK, 8'h0F, 0);
        addv(OP_NINT, 0, 0, 0);
        addv(OP_WR, P_PEND, 8'h02, 0);
        addv(OP_RD, P_PEND, 0, 8'h00);
        addv(OP_NINT, 0, 0, 1);
        addv(OP_NORD, 8'h03, 0, 0);
        addv(OP_NORD, 8'h08, 0, 0);
`ifndef Z80_INT_CTRL_LEVEL_EN
        addv(OP_NORD, P_MODE, 0, 0);
`endif

        doReset();
        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_NINT:  check8($sformatf("t%0d nINT", i), 8'(bus.nINT), tbl[i].exp);
                OP_RD:    readCheck($sformatf("t%0d read %02h", i, tbl[i].a), tbl[i].a, tbl[i].exp);
                OP_NORD: begin
                    ioRead(tbl[i].a, d, oe);
                    check8($sformatf("t%0d unmapped oe %02h", i, tbl[i].a), 8'(oe), 8'h00);
                end
                OP_WR:    ioWrite(tbl[i].a, tbl[i].d);
                OP_PULSE: pulse(int'(tbl[i].a));
                OP_ACK:   ackCheck($sformatf("t%0d ack", i), tbl[i].exp);
                default: ;
            endcase
        end

        // irq_in rise to nINT low takes exactly four clocks.
        doReset();
        ioWrite(P_MASK, 8'h0F);
        irq_in[1] = 1'b1;
        @(negedge CLK);
        irq_in[1] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check8("latency nINT at 3", 8'(bus.nINT), 8'h01);
        @(negedge CLK);
        check8("latency nINT at 4", 8'(bus.nINT), 8'h00);

        // Re-enabling a pending channel through MASK.
        ioWrite(P_MASK, 8'h00);
        check8("mask off nINT", 8'(bus.nINT), 8'h01);
        bus.Address = P_MASK; bus.DataIn = 8'h0F; bus.IORQ = 1'b1; bus.WR = 1'b1;
        @(negedge CLK);
        bus.IORQ = 1'b0; bus.WR = 1'b0;
        check8("mask on nINT at 1", 8'(bus.nINT), 8'h01);
        @(negedge CLK);
        check8("mask on nINT at 2", 8'(bus.nINT), 8'h00);

        // New edge on channel 1 lands in the same cycle as a W1C of that bit.
        irq_in[1] = 1'b1;
        @(negedge CLK);
        irq_in[1] = 1'b0;
        @(negedge CLK);
        bus.Address = P_PEND; bus.DataIn = 8'h02; bus.IORQ = 1'b1; bus.WR = 1'b1;
        @(negedge CLK);
        bus.IORQ = 1'b0; bus.WR = 1'b0;
        @(negedge CLK);
        readCheck("edge vs w1c pend", P_PEND, 8'h02);

        // New edge on channel 1 lands on the acknowledge edge that services channel 1.
        irq_in[1] = 1'b1;
        @(negedge CLK);
        irq_in[1] = 1'b0;
        @(negedge CLK);
        ackCheck("edge vs ack", 8'h82);
        readCheck("edge vs ack pend", P_PEND, 8'h02);
        readCheck("edge vs ack isr", P_ISR, 8'h02);

        // Reset while the vector is on the bus.
        bus.M1 = 1'b1; bus.IORQ = 1'b1;
        @(negedge CLK);
        check8("pre-reset ack oe", 8'(bus.DataOE), 8'h01);
        nRESET = 1'b0;
        @(negedge CLK);
        check8("reset ack oe", 8'(bus.DataOE), 8'h00);
        check8("reset ack data", bus.DataOut, 8'h00);
        check8("reset ack nINT", 8'(bus.nINT), 8'h01);
        nRESET = 1'b1; bus.M1 = 1'b0; bus.IORQ = 1'b0;
        @(negedge CLK);
        check8("post-reset idle oe", 8'(bus.DataOE), 8'h00);
        readCheck("post-reset pend", P_PEND, 8'h00);
        readCheck("post-reset mask", P_MASK, 8'h00);
        readCheck("post-reset isr", P_ISR, 8'h00);

`ifdef Z80_INT_CTRL_LEVEL_EN
        doReset();
        readCheck("mode reset", P_MODE, 8'h00);
        ioWrite(P_MASK, 8'h01);
        ioWrite(P_MODE, 8'h01);
        readCheck("mode rw", P_MODE, 8'h01);
        irq_in[0] = 1'b1;
        repeat (4) @(negedge CLK);
        check8("level nINT", 8'(bus.nINT), 8'h00);
        ackCheck("level ack", 8'h80);
        readCheck("level pend after ack", P_PEND, 8'h01);
        readCheck("level isr", P_ISR, 8'h01);
        ioWrite(P_PEND, 8'h01);
        readCheck("level w1c ignored", P_PEND, 8'h01);
        irq_in[0] = 1'b0;
        repeat (3) @(negedge CLK);
        readCheck("level pend dropped", P_PEND, 8'h00);
        ioWrite(P_ISR, 8'h00);
        readCheck("level eoi", P_ISR, 8'h00);
`endif

        // Randomized operations against the register-level reference.
        doReset();
        mPend = 8'h00; mMask = 8'h00; mIsr = 8'h00;
        for (int n = 0; n < 300; n++) begin
            int op;
            int c;
            logic [7:0] r;
            logic [7:0] expV;
            op = $urandom_range(0, 5);
            r  = 8'($urandom);
            case (op)
                0: begin
                    c = $urandom_range(0, NUM_CH - 1);
                    pulse(c);
                    mPend[c] = 1'b1;
                end
                1: begin
                    ioWrite(P_MASK, r);
                    mMask = r & CHM;
                end
                2: begin
                    ioWrite(P_PEND, r);
                    mPend = mPend & ~r;
                end
                3: begin
                    c = modelPick();
                    expV = (c < 0) ? VEC_BASE + 8'(2 * NUM_CH) : VEC_BASE + 8'(2 * c);
                    ackCheck($sformatf("rnd%0d ack", n), expV);
                    if (c >= 0) begin
                        mPend[c] = 1'b0;
                        mIsr[c]  = 1'b1;
                    end
                end
                4: begin
                    ioWrite(P_ISR, r);
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (mIsr[i]) begin
                            mIsr[i] = 1'b0;
                            break;
                        end
                    end
                end
                default: begin
                    c = $urandom_range(0, 2);
                    expV = (c == 0) ? mPend : (c == 1) ? mMask : mIsr;
                    readCheck($sformatf("rnd%0d read %0d", n, c), IO_PORT + 8'(c), expV);
                end
            endcase
            check8($sformatf("rnd%0d nINT", n), 8'(bus.nINT), (modelPick() < 0) ? 8'h01 : 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/z80_int_ctrl.md
# z80_int_ctrl

Parametrised, IO-mapped interrupt controller for the A-Z80 host board, replacing the direct key-to-`nINT` wiring and the fixed IM2 vector. Up to 8 request lines are synchronised, edge-latched, masked and priority-encoded into a single `nINT`. On the interrupt-acknowledge cycle the block drives a per-channel IM2 vector, with nesting handled by an in-service register. Runs on the CPU clock and sits beside the RAM and UART on the shared data bus.

## Interface
- `NUM_CH`, 4: number of request channels, 1..8; channel 0 has the highest priority.
- `VEC_BASE`, 8'h80: vector for channel 0; channel i gets `VEC_BASE + 2*i`. Must be even and ≤ 8'hEE.
- `IO_PORT`, 8'h04: base IO port compared against `Address`; four consecutive ports are used.
- `CLK` in 1: CPU clock; all state changes on its rising edge.
- `nRESET` in 1: synchronous, active-low reset.
- `irq_in` in NUM_CH: raw active-high requests, asynchronous.
- `Address` in 8: A[15:8].
- `IORQ`, `RD`, `WR`, `M1` in 1 each: active-high bus strobes (inverted CPU pins).
- `DataIn` in 8: CPU data bus.
- `DataOut` out 8: read/vector data.
- `DataOE` out 1: high when the block drives the bus.
- `nINT` out 1: active-low interrupt request to the CPU.

## Operation
- Per channel: 2-FF synchroniser, then rising-edge detect sets `PEND[i]`.
- Registers, bits ≥ NUM_CH read 0 and ignore writes:
  - `IO_PORT+0` PEND: read; write-1-to-clear.
  - `IO_PORT+1` MASK: read/write; 1 = enabled.
  - `IO_PORT+2` ISR: read; any write = EOI, clearing the lowest-index set ISR bit.
  - `IO_PORT+3` MODE: see Configuration.
- Eligible channel: `PEND[i] & MASK[i]` and i is lower than the lowest set ISR index (no ISR bit set means any channel qualifies).
- `nINT` = 0 iff any channel is eligible; registered.
- Acknowledge (`M1 & IORQ`): on the first cycle of ack, latch the lowest-index eligible channel c, clear `PEND[c]`, set `ISR[c]`, and latch vector `VEC_BASE + 2*c`.
  - If no channel is eligible at the ack edge: latch spurious vector `VEC_BASE + 2*NUM_CH`; no state change.
- Register write: `IORQ & WR & !M1 & port match`, acted on once per bus cycle at the rising edge of the qualified strobe.
- Register read: `IORQ & RD & !M1 & port match`; unmatched ports are never driven.
- Simultaneous events:
  - A new edge and a W1C on the same bit in the same cycle: set wins.
  - A new edge on the channel being acknowledged in the same cycle: PEND stays set.
  - EOI and ack in the same cycle cannot occur, since bus cycles are exclusive.
- Reset, including mid-ack: PEND, MASK, ISR, MODE and synchronisers = 0; `nINT`=1; `DataOE`=0; `DataOut`=0.

## Timing
- `irq_in` rise → `nINT` low: 4 CLK (2 sync, 1 edge/PEND, 1 `nINT` register), provided the channel is masked in and not blocked.
- MASK write enabling an already-pending channel → `nINT` low 2 CLK after the write edge.
- `DataOE`/`DataOut` for register reads: combinational from the strobes and address, so data is valid in the same cycle the strobes are seen.
- Vector: `DataOE`=1 and `DataOut`=latched vector from the cycle after the ack edge until `M1 & IORQ` deasserts. The CPU samples in T3 of the ack cycle, ≥2 CLK after IORQ.
- ISR set at the ack edge blocks same- and lower-priority channels, so `nINT` deasserts 1 CLK after ack if nothing of higher priority is eligible.

## Configuration
- `Z80_INT_CTRL_LEVEL_EN` defined:
  - MODE register at `IO_PORT+3` is implemented (read/write, reset 0).
  - `MODE[i]`=1: channel i is level-sensitive. `PEND[i]` follows the synchronised level, W1C has no effect, and ack sets `ISR[i]` without clearing PEND.
- Not defined:
  - All channels are edge-triggered.
  - `IO_PORT+3` is unmapped: not driven, writes ignored.

## Test plan
- Reset with `NUM_CH`=4 → `nINT`=1, `DataOE`=0, and reads of ports 0x04/0x05/0x06 return 0x00.
- MASK=0x0F, pulse `irq_in[2]` → `nINT` low after 4 CLK; the ack cycle drives 0x84; then PEND=0x00, ISR=0x04, `nINT`=1.
- With ISR=0x04, pulse `irq_in[3]` → `nINT` stays 1. Pulse `irq_in[0]` → ack drives 0x80 and ISR=0x05. EOI → ISR=0x04. A second EOI → ISR=0x00, after which channel 3 asserts `nINT` and ack drives 0x86.
- `irq_in[1]` edge coincident with a W1C of 0x02 → PEND bit 1 remains 1. Ack after MASK is cleared to 0x00 mid-request → vector 0x88 and no state change.
- Assert `nRESET` during an active ack → next cycle `DataOE`=0 and all registers 0.
- With `Z80_INT_CTRL_LEVEL_EN`: MODE=0x01, hold `irq_in[0]` high → ack drives 0x80, and PEND[0] stays 1 until the input drops; W1C of 0x01 is ignored.
